pe_ws_dbuf: RTL and testbench
=============================

// Module: pe_ws_dbuf
// PURPOSE
//  Weight-stationary systolic PE, next generation of the array PE: parametrised widths, signed/unsigned arithmetic,
//  double-buffered weights (load next tile while computing current), valid handshake along rows and columns.
//  Tiled in an R x C grid: activations flow left->right, partial sums and weight-load data flow top->bottom.
// PARAMETERS
//  ADD_BW  32  partial-sum width (i_top/o_bot)
//  MUL_BW  16  activation/weight width (i_left/o_right, weight banks)
//  SIGNED  0   1: operands and psums are two's complement; 0: unsigned
// PORTS
//  clk            in   1       clock, all state updates on rising edge
//  rst            in   1       synchronous reset, active-low
//  i_load         in   1       weight-load strobe; i_top[MUL_BW-1:0] is the weight word
//  i_swap         in   1       swap active/shadow weight banks
//  i_valid        in   1       compute strobe; i_top = psum in, i_left = activation
//  i_top          in   ADD_BW  psum in (compute) / weight word in (load)
//  i_left         in   MUL_BW  activation in
//  o_bot          out  ADD_BW  psum out (compute) / forwarded weight word (load)
//  o_valid        out  1       o_bot holds a valid psum
//  o_load         out  1       o_bot holds a forwarded weight word (drives i_load of PE below)
//  o_right        out  MUL_BW  registered activation out
//  o_right_valid  out  1       registered i_valid, to PE on the right
//  o_err          out  1       sticky: load/compute collision seen
// BEHAVIOUR
//  - Reset (rst==0 at edge): both weight banks=0, bank_sel=0, o_bot=0, o_right=0, all flags=0. Mid-operation reset
//    discards in-flight data; first valid output possible 1 cycle after rst returns high.
//  - Latency: every output is registered, 1 cycle from inputs. o_right/o_right_valid update every cycle
//    (o_right <= i_left, o_right_valid <= i_valid & ~i_load).
//  - Load (i_load=1): shadow <= i_top[MUL_BW-1:0]; o_bot <= zero-extended old shadow; o_load <= 1; o_valid <= 0.
//    A column of N PEs is an N-stage weight shift chain: N load cycles fill it, bottom-row word first.
//  - Compute (i_valid=1, i_load=0): o_bot <= i_top + active*i_left; o_valid <= 1; o_load <= 0.
//    Product is 2*MUL_BW bits, sign- (SIGNED=1) or zero-extended (SIGNED=0) / truncated to ADD_BW before the add.
//    Without saturation the sum wraps modulo 2^ADD_BW.
//  - Idle (neither): o_valid <= 0, o_load <= 0, o_bot holds.
//  - Swap (i_swap=1): bank_sel toggles at the edge. Compute in the same cycle uses the pre-swap active bank; load in
//    the same cycle writes the post-swap shadow (the previously active bank).
//  - Collision (i_load & i_valid): load wins, compute dropped (o_valid=0), o_err <= 1 until reset.
//  - Unloaded bank is 0 after reset: compute then passes i_top through unchanged.
// CONFIGURATION
//  PE_SAT_EN defined: accumulate saturates. SIGNED=0 clamps to 2^ADD_BW-1; SIGNED=1 clamps to
//    2^(ADD_BW-1)-1 / -2^(ADD_BW-1) on positive/negative overflow.
//  PE_SAT_EN undefined: wrap-around add, no clamp logic synthesised.
// STRUCTURE
//  - pe_pkg: default widths, the bank-index type (1 bit), and saturation bound constants as functions of ADD_BW/SIGNED.
//  - Sub-module pe_mac: combinational multiply, extend, add, optional clamp (PE_SAT_EN). Parameters ADD_BW/MUL_BW/SIGNED.
//  - Top level: bank registers, bank_sel, output registers, sticky error.
// TESTING
//  1 Load/swap/compute, SIGNED=0: load 0x0003, swap, i_valid i_top=0x10 i_left=0x0005 -> next cycle o_bot=0x1F,
//    o_valid=1, o_right=0x0005.
//  2 Double buffer: with active=3, load 0x0007 while computing i_top=0 i_left=2 -> o_bot=6; after swap the same
//    input -> o_bot=0xE. Swap+compute same cycle -> still 6.
//  3 Chain: 3 consecutive loads 0xA,0xB,0xC -> o_bot 0x0,0xA,0xB with o_load=1; shadow=0xC.
//  4 Signed, SIGNED=1: weight 0xFFFF, i_left=0x0004, i_top=0 -> o_bot=0xFFFFFFFC.
//  5 Overflow: SIGNED=0, weight 2, i_left=0x10, i_top=0xFFFFFFF0 -> 0xFFFFFFFF with PE_SAT_EN, 0x00000010 without.
//    SIGNED=1, weight 0x7FFF, i_left=0x7FFF, i_top=0x7FFFFFFF -> 0x7FFFFFFF with PE_SAT_EN.
//  6 Collision then reset: i_load=i_valid=1 -> o_valid=0, o_err=1, shadow updated; rst=0 one cycle -> all outputs 0,
//    o_err=0, banks 0.

Source files
------------

// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared widths, bank index type and saturation bounds for the weight-stationary PE
package pe_pkg;

    localparam int DEF_ADD_BW = 32;
    localparam int DEF_MUL_BW = 16;
    localparam int SAT_BW     = 64;

    typedef logic bank_idx_t;

    // Bounds are returned SAT_BW wide; callers slice the low add_bw bits.
    function automatic logic [SAT_BW-1:0] sat_max(input int add_bw, input bit sgn);
        logic [SAT_BW-1:0] one;
        one = SAT_BW'(1);
        sat_max = sgn ? ((one << (add_bw - 1)) - one) : ((one << add_bw) - one);
    endfunction

    function automatic logic [SAT_BW-1:0] sat_min(input int add_bw, input bit sgn);
        logic [SAT_BW-1:0] one;
        one = SAT_BW'(1);
        sat_min = sgn ? (one << (add_bw - 1)) : '0;
    endfunction

endpackage

// File: rtl/pe_mac.sv
// rtl/pe_mac.sv - combinational multiply-accumulate; PE_SAT_EN selects clamping instead of wrap-around
module pe_mac
    import pe_pkg::*;
#(
    parameter int ADD_BW = DEF_ADD_BW,
    parameter int MUL_BW = DEF_MUL_BW,
    parameter bit SIGNED = 1'b0
) (
    input  logic [ADD_BW-1:0] psum,
    input  logic [MUL_BW-1:0] act,
    input  logic [MUL_BW-1:0] wgt,
    output logic [ADD_BW-1:0] sum
);

    logic [2*MUL_BW-1:0] act_x;
    logic [2*MUL_BW-1:0] wgt_x;
    logic [2*MUL_BW-1:0] prod;
    logic [ADD_BW-1:0]   prod_a;

    // Extending the operands first makes the low 2*MUL_BW product bits correct for either signedness.
    assign act_x = {{MUL_BW{SIGNED & act[MUL_BW-1]}}, act};
    assign wgt_x = {{MUL_BW{SIGNED & wgt[MUL_BW-1]}}, wgt};
    assign prod  = act_x * wgt_x;

    generate
        if (ADD_BW > 2*MUL_BW) begin : g_ext
            assign prod_a = {{(ADD_BW-2*MUL_BW){SIGNED & prod[2*MUL_BW-1]}}, prod};
        end else if (ADD_BW == 2*MUL_BW) begin : g_eq
            assign prod_a = prod;
        end else begin : g_trunc
            assign prod_a = prod[ADD_BW-1:0];
        end
    endgenerate

`ifdef PE_SAT_EN
    localparam logic [SAT_BW-1:0] HI_W = sat_max(ADD_BW, SIGNED);
    localparam logic [SAT_BW-1:0] LO_W = sat_min(ADD_BW, SIGNED);
    localparam logic [ADD_BW-1:0] HI   = HI_W[ADD_BW-1:0];
    localparam logic [ADD_BW-1:0] LO   = LO_W[ADD_BW-1:0];

    logic [ADD_BW:0] wide;

    assign wide = {SIGNED & psum[ADD_BW-1], psum} + {SIGNED & prod_a[ADD_BW-1], prod_a};

    // Signed overflow shows as the guard bit disagreeing with the result sign bit.
    always_comb begin
        sum = wide[ADD_BW-1:0];
        if (SIGNED) begin
            if (wide[ADD_BW] != wide[ADD_BW-1]) begin
                sum = wide[ADD_BW] ? LO : HI;
            end
        end else if (wide[ADD_BW]) begin
            sum = HI;
        end
    end
`else
    assign sum = psum + prod_a;
`endif

endmodule

// File: rtl/pe_ws_dbuf.sv
// rtl/pe_ws_dbuf.sv - weight-stationary systolic PE with double-buffered weights; PE_SAT_EN enables saturating accumulate
module pe_ws_dbuf
    import pe_pkg::*;
#(
    parameter int ADD_BW = DEF_ADD_BW,
    parameter int MUL_BW = DEF_MUL_BW,
    parameter bit SIGNED = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_swap,
    input  logic              i_valid,
    input  logic [ADD_BW-1:0] i_top,
    input  logic [MUL_BW-1:0] i_left,
    output logic [ADD_BW-1:0] o_bot,
    output logic              o_valid,
    output logic              o_load,
    output logic [MUL_BW-1:0] o_right,
    output logic              o_right_valid,
    output logic              o_err
);

    logic [MUL_BW-1:0] bank [2];
    bank_idx_t         bank_sel;
    bank_idx_t         shadow_idx;
    logic [MUL_BW-1:0] active_w;
    logic [MUL_BW-1:0] shadow_old;
    logic [ADD_BW-1:0] mac_sum;

    // Compute sees the pre-swap active bank; load targets the post-swap shadow.
    assign active_w   = bank[bank_sel];
    assign shadow_idx = ~(bank_sel ^ i_swap);
    assign shadow_old = bank[shadow_idx];

    pe_mac #(
        .ADD_BW (ADD_BW),
        .MUL_BW (MUL_BW),
        .SIGNED (SIGNED)
    ) u_mac (
        .psum (i_top),
        .act  (i_left),
        .wgt  (active_w),
        .sum  (mac_sum)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            bank[0]       <= '0;
            bank[1]       <= '0;
            bank_sel      <= 1'b0;
            o_bot         <= '0;
            o_valid       <= 1'b0;
            o_load        <= 1'b0;
            o_right       <= '0;
            o_right_valid <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            o_right       <= i_left;
            o_right_valid <= i_valid & ~i_load;
            bank_sel      <= bank_sel ^ i_swap;
            if (i_load) begin
                bank[shadow_idx] <= i_top[MUL_BW-1:0];
                o_bot            <= ADD_BW'(shadow_old);
                o_load           <= 1'b1;
                o_valid          <= 1'b0;
                if (i_valid) begin
                    o_err <= 1'b1;
                end
            end else if (i_valid) begin
                o_bot   <= mac_sum;
                o_valid <= 1'b1;
                o_load  <= 1'b0;
            end else begin
                o_valid <= 1'b0;
                o_load  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pe_ws_dbuf.sv
// tb/tb_pe_ws_dbuf.sv - directed checks of unsigned and signed PE instances driven in lockstep
module tb_pe_ws_dbuf;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_load, i_swap, i_valid;
    logic [31:0] i_top;
    logic [15:0] i_left;

    logic [31:0] u_bot, s_bot;
    logic        u_valid, s_valid, u_load, s_load, u_rv, s_rv, u_err, s_err;
    logic [15:0] u_right, s_right;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pe_ws_dbuf #(.ADD_BW(32), .MUL_BW(16), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .i_load(i_load), .i_swap(i_swap), .i_valid(i_valid),
        .i_top(i_top), .i_left(i_left), .o_bot(u_bot), .o_valid(u_valid), .o_load(u_load),
        .o_right(u_right), .o_right_valid(u_rv), .o_err(u_err)
    );

    pe_ws_dbuf #(.ADD_BW(32), .MUL_BW(16), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .i_load(i_load), .i_swap(i_swap), .i_valid(i_valid),
        .i_top(i_top), .i_left(i_left), .o_bot(s_bot), .o_valid(s_valid), .o_load(s_load),
        .o_right(s_right), .o_right_valid(s_rv), .o_err(s_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic ld, input logic sw, input logic vl,
                        input logic [31:0] top, input logic [15:0] left);
        i_load  = ld;
        i_swap  = sw;
        i_valid = vl;
        i_top   = top;
        i_left  = left;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b1, 32'h0000_00FF, 16'h00AA);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        i_load = 0; i_swap = 0; i_valid = 0; i_top = 0; i_left = 0;
        #2;

        // Reset state
        do_reset();
        check("rst_bot", u_bot, 32'h0);
        check("rst_valid", {31'b0, u_valid}, 32'h0);
        check("rst_load", {31'b0, u_load}, 32'h0);
        check("rst_right", {16'b0, u_right}, 32'h0);
        check("rst_rv", {31'b0, u_rv}, 32'h0);
        check("rst_err", {31'b0, u_err}, 32'h0);

        // Unloaded bank passes psum through
        step(0, 0, 1, 32'h55, 16'h0007);
        check("pass_u", u_bot, 32'h55);
        check("pass_s", s_bot, 32'h55);

        // Weight shift chain
        step(1, 0, 0, 32'hA, 16'h0);
        check("chain0_bot", u_bot, 32'h0);
        check("chain0_load", {31'b0, u_load}, 32'h1);
        check("chain0_valid", {31'b0, u_valid}, 32'h0);
        step(1, 0, 0, 32'hB, 16'h0);
        check("chain1_bot", u_bot, 32'hA);
        step(1, 0, 0, 32'hC, 16'h0);
        check("chain2_bot", u_bot, 32'hB);
        check("chain2_load", {31'b0, u_load}, 32'h1);
        step(0, 1, 0, 32'h0, 16'h0);
        check("swap_idle_load", {31'b0, u_load}, 32'h0);
        step(0, 0, 1, 32'h0, 16'h0001);
        check("chain_shadow", u_bot, 32'hC);

        // Load, swap, compute
        do_reset();
        step(1, 0, 0, 32'h3, 16'h0);
        check("t1_load_rv", {31'b0, u_rv}, 32'h0);
        step(0, 1, 0, 32'h0, 16'h0);
        step(0, 0, 1, 32'h10, 16'h0005);
        check("t1_bot", u_bot, 32'h1F);
        check("t1_valid", {31'b0, u_valid}, 32'h1);
        check("t1_right", {16'b0, u_right}, 32'h5);
        check("t1_rv", {31'b0, u_rv}, 32'h1);
        check("t1_bot_s", s_bot, 32'h1F);

        // Idle holds o_bot
        step(0, 0, 0, 32'h1234, 16'h0009);
        check("idle_bot", u_bot, 32'h1F);
        check("idle_valid", {31'b0, u_valid}, 32'h0);
        check("idle_right", {16'b0, u_right}, 32'h9);

        // Double buffer
        step(1, 0, 0, 32'h7, 16'h0);
        check("t2_load_bot", u_bot, 32'h0);
        step(0, 0, 1, 32'h0, 16'h0002);
        check("t2_pre", u_bot, 32'h6);
        step(0, 1, 1, 32'h0, 16'h0002);
        check("t2_swapcomp", u_bot, 32'h6);
        step(0, 0, 1, 32'h0, 16'h0002);
        check("t2_post", u_bot, 32'hE);

        // Signed vs unsigned multiply
        do_reset();
        step(1, 0, 0, 32'hFFFF, 16'h0);
        step(0, 1, 0, 32'h0, 16'h0);
        step(0, 0, 1, 32'h0, 16'h0004);
        check("t4_signed", s_bot, 32'hFFFF_FFFC);
        check("t4_unsigned", u_bot, 32'h0003_FFFC);

        // Overflow behaviour
        do_reset();
        step(1, 0, 0, 32'h2, 16'h0);
        step(0, 1, 0, 32'h0, 16'h0);
        step(0, 0, 1, 32'hFFFF_FFF0, 16'h0010);
`ifdef PE_SAT_EN
        check("t5_u_ovf", u_bot, 32'hFFFF_FFFF);
`else
        check("t5_u_ovf", u_bot, 32'h0000_0010);
`endif
        check("t5_s_noovf", s_bot, 32'h0000_0010);

        step(1, 0, 0, 32'h7FFF, 16'h0);
        step(0, 1, 0, 32'h0, 16'h0);
        step(0, 0, 1, 32'h7FFF_FFFF, 16'h7FFF);
`ifdef PE_SAT_EN
        check("t5_s_pos", s_bot, 32'h7FFF_FFFF);
`else
        check("t5_s_pos", s_bot, 32'hBFFF_0000);
`endif
        check("t5_u_big", u_bot, 32'hBFFF_0000);

        step(1, 0, 0, 32'h8000, 16'h0);
        step(0, 1, 0, 32'h0, 16'h0);
        step(0, 0, 1, 32'h8000_0000, 16'h7FFF);
`ifdef PE_SAT_EN
        check("t5_s_neg", s_bot, 32'h8000_0000);
`else
        check("t5_s_neg", s_bot, 32'h4000_8000);
`endif
        check("t5_u_neg", u_bot, 32'hBFFF_8000);

        // Collision: load wins, error sticks
        step(1, 0, 1, 32'h1234, 16'h0003);
        check("t6_valid", {31'b0, u_valid}, 32'h0);
        check("t6_load", {31'b0, u_load}, 32'h1);
        check("t6_err", {31'b0, u_err}, 32'h1);
        check("t6_rv", {31'b0, u_rv}, 32'h0);
        check("t6_bot", u_bot, 32'h7FFF);
        step(0, 1, 0, 32'h0, 16'h0);
        check("t6_err_sticky", {31'b0, u_err}, 32'h1);
        step(0, 0, 1, 32'h0, 16'h0001);
        check("t6_shadow", u_bot, 32'h1234);
        check("t6_err_s", {31'b0, s_err}, 32'h1);

        // Reset clears everything, including both banks
        do_reset();
        check("t6r_bot", u_bot, 32'h0);
        check("t6r_valid", {31'b0, u_valid}, 32'h0);
        check("t6r_err", {31'b0, u_err}, 32'h0);
        check("t6r_right", {16'b0, u_right}, 32'h0);
        step(0, 0, 1, 32'h5, 16'h0003);
        check("t6r_bank0", u_bot, 32'h5);
        step(0, 1, 0, 32'h0, 16'h0);
        step(0, 0, 1, 32'h5, 16'h0003);
        check("t6r_bank1", u_bot, 32'h5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
